sd_wb_master_arb: RTL and testbench

- Shares the single SD-controller Wishbone DMA master port between two requesters.
- Port 0 is the RX FIFO filler, which writes card data into system memory.
- Port 1 is the TX FIFO filler, which reads system memory for the card.
- Arbitration is round-robin with grant hold for the whole requester cycle. A bus watchdog aborts stalled transfers and reports them to the data master controller.

---
 rtl/sd_wb_master_arb_pkg.sv | 13 +
 rtl/sd_wb_watchdog.sv | 32 +++
 rtl/sd_wb_master_arb.sv | 121 ++++++++++++
 tb/tb_sd_wb_master_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wb_master_arb_pkg.sv
// Shared constants for the SD controller Wishbone DMA master arbiter.
package sd_wb_master_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    // Bus watchdog default, alongside the other SD defines; 0 disables it.
    localparam int SD_WB_TIMEOUT = 255;
    localparam int SD_WB_TO_W    = 8;

endpackage

// File: rtl/sd_wb_watchdog.sv
// Counts stalled strobe cycles and flags the cycle on which the limit is hit without ack.
module sd_wb_watchdog
    import sd_wb_master_arb_pkg::*;
#(
    parameter int TIMEOUT = SD_WB_TIMEOUT,
    parameter int TO_W    = SD_WB_TO_W
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] tcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (!stb || ack) begin
            tcnt <= '0;
        end else if (tcnt != '1) begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    // An ack landing on the limit cycle completes the beat instead of aborting it.
    assign expire = (TIMEOUT != 0) && stb && !ack && (tcnt == LIMIT);

endmodule

// File: rtl/sd_wb_master_arb.sv
// Round-robin arbiter sharing the SD DMA Wishbone master between the RX and TX FIFO fillers.
module sd_wb_master_arb
    import sd_wb_master_arb_pkg::*;
#(
    parameter int TIMEOUT = SD_WB_TIMEOUT,
    parameter int TO_W    = SD_WB_TO_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    logic [1:0] state, state_nxt;
    logic       last_served, last_nxt;   // 0 = RX, 1 = TX
    logic       gnt0, gnt1, expire;

    assign gnt0  = (state == ST_GNT0);
    assign gnt1  = (state == ST_GNT1);
    assign gnt_o = {gnt1, gnt0};

    // Wishbone: a beat completes on a cycle with cyc & stb & ack; the owner keeps cyc for the burst.
    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        if (gnt0) begin
            m_wb_adr_o = m0_adr_i;
            m_wb_dat_o = m0_dat_i;
            m_wb_we_o  = m0_we_i;
            m_wb_cyc_o = m0_cyc_i;
            m_wb_stb_o = m0_stb_i;
        end else if (gnt1) begin
            m_wb_adr_o = m1_adr_i;
            m_wb_we_o  = m1_we_i;
            m_wb_cyc_o = m1_cyc_i;
            m_wb_stb_o = m1_stb_i;
        end
    end

    assign m0_ack_o = gnt0 & m_wb_ack_i;
    assign m1_ack_o = gnt1 & m_wb_ack_i;
    assign m1_dat_o = gnt1 ? m_wb_dat_i : '0;

    sd_wb_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .stb    (m_wb_stb_o),
        .ack    (m_wb_ack_i),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        last_nxt  = last_served;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last_served ? ST_GNT0 : ST_GNT1;
                else if (m0_cyc_i)        state_nxt = ST_GNT0;
                else if (m1_cyc_i)        state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                if (expire || !m0_cyc_i) begin
                    state_nxt = expire ? ST_ABORT : ST_IDLE;
                    last_nxt  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (expire || !m1_cyc_i) begin
                    state_nxt = expire ? ST_ABORT : ST_IDLE;
                    last_nxt  = 1'b1;
                end
            end
            // last_served names the offending port while aborting.
            ST_ABORT: begin
                if (last_served ? !m1_cyc_i : !m0_cyc_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last_served <= 1'b1;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            m0_err_o    <= gnt0 & expire;
            m1_err_o    <= gnt1 & expire;
            timeout_o   <= (gnt0 | gnt1) & expire;
        end
    end

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Bench for sd_wb_master_arb: directed scenarios plus random traffic against a behavioural model.
module tb_sd_wb_master_arb;

    localparam int TMO = 8;

    logic        clk, rst;
    logic [31:0] adr [2];
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] rx_dat;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o;
    logic [31:0] m1_dat_o, m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i;
    logic [1:0]  gnt_o;

    int          checks = 0;
    int          errors = 0;
    int          delay_rx, delay_tx;
    bit          fixed_rdata;
    logic [31:0] rdata_val;
    logic [1:0]  exp_q[$];

    sd_wb_master_arb #(.TIMEOUT(TMO), .TO_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_adr_i   (adr[0]),
        .m0_dat_i   (rx_dat),
        .m0_we_i    (we[0]),
        .m0_cyc_i   (cyc[0]),
        .m0_stb_i   (stb[0]),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_adr_i   (adr[1]),
        .m1_we_i    (we[1]),
        .m1_cyc_i   (cyc[1]),
        .m1_stb_i   (stb[1]),
        .m1_dat_o   (m1_dat_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i),
        .gnt_o      (gnt_o),
        .timeout_o  (timeout_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "bench stopped");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? m0_ack_o : m1_ack_o;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 0) ? m0_err_o : m1_err_o;
    endfunction

    // Driver: one requester cycle of 'beats' beats; ends early on err or reset.
    task automatic master_txn(input int p, input int beats, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        int  b, guard;
        bit  done;
        @(posedge clk); #1;
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a;
        if (p == 0) rx_dat = d;
        b = 0; guard = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (!rst || err_of(p)) begin
                done = 1;
            end else if (ack_of(p)) begin
                b++;
                if (b >= beats) done = 1;
            end else if (guard > 300) begin
                checks++; errors++;
                $display("FAIL master%0d_stuck at %0t: got no ack after %0d cycles, need ack or err", p, $time, guard);
                done = 1;
            end
            if (!done && ack_of(p)) begin
                @(posedge clk); #1;
                adr[p] = adr[p] + 32'd4;
                if (p == 0) rx_dat = $urandom;
            end
        end
        @(posedge clk); #1;
        cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
    endtask

    // Slave: acks after a per-beat wait (negative delay = random, 10 = stall past the watchdog).
    initial begin
        int wcnt, delay, sel;
        bit fresh;
        wcnt = 0; delay = 0; fresh = 1;
        m_wb_ack_i = 1'b0; m_wb_dat_i = '0;
        forever begin
            @(posedge clk); #2;
            if (!m_wb_stb_o) begin
                m_wb_ack_i = 1'b0; wcnt = 0; fresh = 1;
            end else begin
                if (fresh) begin
                    sel = gnt_o[1] ? delay_tx : delay_rx;
                    if (sel >= 0) delay = sel;
                    else delay = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
                    fresh = 0;
                end
                if (wcnt == delay) begin
                    m_wb_ack_i = 1'b1; wcnt = 0; fresh = 1;
                end else begin
                    m_wb_ack_i = 1'b0; wcnt++;
                end
            end
            m_wb_dat_i = fixed_rdata ? rdata_val : $urandom;
        end
    end

    // Scoreboard model: owner, offending port, last served, stalled-strobe count, pending pulse.
    int          m_own = -1, m_ab = -1, m_last = 1, m_stall = 0, m_pulse = -1;
    bit          m_hit;
    logic [1:0]  e_gnt;
    logic [31:0] e_adr, e_dat, e_m1dat;
    logic        e_we, e_cyc, e_stb, e_ack0, e_ack1;

    always @(negedge clk) begin
        if (!rst) begin
            m_own = -1; m_ab = -1; m_last = 1; m_stall = 0; m_pulse = -1;
        end
        e_gnt = '0; e_adr = '0; e_dat = '0; e_m1dat = '0;
        e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
        if (m_own >= 0) begin
            e_gnt = (m_own == 0) ? 2'b01 : 2'b10;
            e_adr = adr[m_own]; e_we = we[m_own]; e_cyc = cyc[m_own]; e_stb = stb[m_own];
            if (m_own == 0) begin
                e_dat = rx_dat; e_ack0 = m_wb_ack_i;
            end else begin
                e_ack1 = m_wb_ack_i; e_m1dat = m_wb_dat_i;
            end
        end
        chk("gnt_o", gnt_o, e_gnt);
        chk("m_wb_adr_o", m_wb_adr_o, e_adr);
        chk("m_wb_dat_o", m_wb_dat_o, e_dat);
        chk("m_wb_we_o", m_wb_we_o, e_we);
        chk("m_wb_cyc_o", m_wb_cyc_o, e_cyc);
        chk("m_wb_stb_o", m_wb_stb_o, e_stb);
        chk("m0_ack_o", m0_ack_o, e_ack0);
        chk("m1_ack_o", m1_ack_o, e_ack1);
        chk("m1_dat_o", m1_dat_o, e_m1dat);
        chk("m0_err_o", m0_err_o, m_pulse == 0);
        chk("m1_err_o", m1_err_o, m_pulse == 1);
        chk("timeout_o", timeout_o, m_pulse >= 0);
        if (rst) begin
            m_pulse = -1;
            if (m_ab >= 0) begin
                if (!cyc[m_ab]) m_ab = -1;
            end else if (m_own < 0) begin
                if (cyc[0] && cyc[1]) m_own = 1 - m_last;
                else if (cyc[0])      m_own = 0;
                else if (cyc[1])      m_own = 1;
            end else begin
                m_hit = 0;
                if (stb[m_own] && !m_wb_ack_i) begin
                    if (m_stall == TMO - 1) m_hit = 1;
                    m_stall++;
                end else begin
                    m_stall = 0;
                end
                if (m_hit) begin
                    m_pulse = m_own; m_last = m_own; m_ab = m_own; m_own = -1; m_stall = 0;
                end else if (!cyc[m_own]) begin
                    m_last = m_own; m_own = -1; m_stall = 0;
                end
            end
        end
    end

    task automatic sync_start();
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        delay_rx = 0; delay_tx = 0;
        exp_q = {2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        fork
            master_txn(0, 1, 1'b1, 32'h0000_0100, 32'h0000_0011);
            master_txn(1, 1, 1'b0, 32'h0000_0200, 32'h0);
            begin
                sync_start();
                while (exp_q.size() > 0) begin
                    @(negedge clk);
                    chk("tie_gnt_seq", gnt_o, exp_q.pop_front());
                end
            end
        join
        repeat (2) @(posedge clk);
        fork
            master_txn(0, 1, 1'b1, 32'h0000_0300, 32'h0000_0022);
            master_txn(1, 1, 1'b0, 32'h0000_0400, 32'h0);
            begin
                sync_start();
                @(negedge clk); chk("tie2_wait", gnt_o, 2'b00);
                @(negedge clk); chk("tie2_gnt_rx", gnt_o, 2'b01);
            end
        join
        repeat (2) @(posedge clk);
    endtask

    task automatic test_rx_write();
        delay_rx = 2;
        fork
            master_txn(0, 1, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
            begin
                sync_start();
                @(negedge clk);
                chk("wr_gnt_n0", gnt_o, 2'b00); chk("wr_cyc_n0", m_wb_cyc_o, 1'b0);
                @(negedge clk);
                chk("wr_gnt_n1", gnt_o, 2'b01); chk("wr_adr", m_wb_adr_o, 32'h0000_1000);
                chk("wr_dat", m_wb_dat_o, 32'hA5A5_A5A5); chk("wr_we", m_wb_we_o, 1'b1);
                chk("wr_ack_n1", m0_ack_o, 1'b0);
                @(negedge clk); chk("wr_ack_n2", m0_ack_o, 1'b0);
                @(negedge clk); chk("wr_ack_n3", m0_ack_o, 1'b1);
                @(negedge clk); chk("wr_ack_n4", m0_ack_o, 1'b0); chk("wr_gnt_n4", gnt_o, 2'b01);
                @(negedge clk); chk("wr_gnt_n5", gnt_o, 2'b00);
            end
        join
        repeat (2) @(posedge clk);
    endtask

    task automatic test_tx_read();
        bit seen;
        delay_tx = 1; fixed_rdata = 1; rdata_val = 32'hDEAD_BEEF;
        seen = 0;
        fork
            master_txn(1, 1, 1'b0, 32'h0000_2000, 32'h0);
            begin
                sync_start();
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("rd_no_m0_ack", m0_ack_o, 1'b0);
                    if (m1_ack_o && !seen) begin
                        seen = 1;
                        chk("rd_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
                        chk("rd_adr", m_wb_adr_o, 32'h0000_2000);
                        chk("rd_we", m_wb_we_o, 1'b0);
                    end
                end
                chk("rd_ack_seen", seen, 1'b1);
            end
        join
        fixed_rdata = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        int  nstb;
        bit  seen, got_rx;
        delay_tx = 100; delay_rx = 1;
        nstb = 0; seen = 0; got_rx = 0;
        fork
            master_txn(1, 1, 1'b0, 32'h0000_3000, 32'h0);
            begin
                repeat (3) @(posedge clk);
                master_txn(0, 1, 1'b1, 32'h0000_4000, 32'h1234_5678);
            end
            begin
                sync_start();
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge clk);
                    if (timeout_o) begin
                        seen = 1;
                        chk("abort_stb_cycles", nstb, TMO);
                        chk("abort_m1_err", m1_err_o, 1'b1);
                        chk("abort_m0_err", m0_err_o, 1'b0);
                        chk("abort_cyc", m_wb_cyc_o, 1'b0);
                        chk("abort_gnt", gnt_o, 2'b00);
                    end else if (gnt_o == 2'b10 && m_wb_stb_o) begin
                        nstb++;
                    end
                end
                chk("abort_seen", seen, 1'b1);
                @(negedge clk);
                chk("abort_pulse_end", timeout_o, 1'b0);
                chk("abort_err_end", m1_err_o, 1'b0);
                for (int i = 0; i < 20 && !got_rx; i++) begin
                    @(negedge clk);
                    if (gnt_o == 2'b01) got_rx = 1;
                end
                chk("abort_rx_granted", got_rx, 1'b1);
            end
        join
        repeat (2) @(posedge clk);
    endtask

    task automatic test_late_ack();
        int nstb;
        bit acked, bad;
        delay_tx = TMO - 1;
        nstb = 0; acked = 0; bad = 0;
        fork
            master_txn(1, 1, 1'b0, 32'h0000_5000, 32'h0);
            begin
                sync_start();
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    if (timeout_o || m1_err_o) bad = 1;
                    if (!acked && gnt_o == 2'b10 && m_wb_stb_o) nstb++;
                    if (m1_ack_o) acked = 1;
                end
                chk("late_ack_seen", acked, 1'b1);
                chk("late_ack_cycle", nstb, TMO);
                chk("late_no_err", bad, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        delay_rx = 100;
        fork
            master_txn(0, 1, 1'b1, 32'h0000_6000, 32'h0BAD_F00D);
            begin
                sync_start();
                @(negedge clk);
                @(negedge clk); chk("rstmid_cyc_before", m_wb_cyc_o, 1'b1);
                #2 rst = 1'b0;
                #1;
                chk("rstmid_cyc_async", m_wb_cyc_o, 1'b0);
                chk("rstmid_stb_async", m_wb_stb_o, 1'b0);
                chk("rstmid_gnt_async", gnt_o, 2'b00);
                chk("rstmid_no_err", m0_err_o, 1'b0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        delay_rx = 1;
        fork
            master_txn(0, 1, 1'b1, 32'h0000_7000, 32'h0000_0077);
            begin
                sync_start();
                @(negedge clk); chk("post_rst_wait", gnt_o, 2'b00);
                @(negedge clk); chk("post_rst_gnt", gnt_o, 2'b01);
            end
        join
        repeat (2) @(posedge clk);
    endtask

    task automatic random_phase();
        delay_rx = -1; delay_tx = -1;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    master_txn(0, int'($urandom_range(1, 3)), 1'b1, $urandom, $urandom);
                end
            end
            begin
                for (int j = 0; j < 15; j++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    master_txn(1, int'($urandom_range(1, 3)), 1'b0, $urandom, 32'h0);
                end
            end
        join
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0;
        end
        rx_dat = '0; delay_rx = 0; delay_tx = 0; fixed_rdata = 0; rdata_val = '0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt_o, 2'b00);
        chk("reset_cyc", m_wb_cyc_o, 1'b0);
        chk("reset_timeout", timeout_o, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        test_tie();
        test_rx_write();
        test_tx_read();
        test_abort();
        test_late_ack();
        test_reset_mid();
        random_phase();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
